// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB write-sequencing logic.
// Latency: n/a (types, constants and a pure index function only).
// Backpressure: n/a.
package btb_pkg;

    localparam int DEF_BTB_ENTRIES  = 64;
    localparam int DEF_INDEX_WIDTH  = $clog2(DEF_BTB_ENTRIES);
    localparam int DEF_TARGET_WIDTH = 32;
    localparam int DEF_QUEUE_DEPTH  = 4;

    // One resolved-branch update as captured from EX
    typedef struct packed {
        logic [31:0]                 pc;
        logic                        taken;
        logic [DEF_TARGET_WIDTH-1:0] target;
    } btb_update_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } ctrl_state_e;

    // BTB index is the word-aligned PC bits just above the byte offset
    function automatic logic [DEF_INDEX_WIDTH-1:0] btb_index(input logic [31:0] pc);
        return DEF_INDEX_WIDTH'(pc >> 2);
    endfunction

endpackage

// File: rtl/btb_update_queue.sv
// Small synchronous FIFO of pending BTB updates; head and the entry behind it are visible.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: caller gates push with full/pop; push and pop on the same edge are legal when full.
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  btb_update_t                push_dat,
    input  logic                       pop,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output btb_update_t                head,
    output btb_update_t                head_next,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    btb_update_t       mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    // Pointer and occupancy tracking; clear drops all entries at once
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: occupancy decides what is meaningful
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PW'(1)];
    assign count     = cnt;

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB writes: post-reset/flush invalidate sweep, then queued EX updates.
// Latency: update at edge N into empty queue is presented on btbWr* after edge N+1.
// Backpressure: btbWr* held while btbWrReady=0; EX has none, overflow is counted in dropCount.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int BTB_ENTRIES  = DEF_BTB_ENTRIES,
    parameter int INDEX_WIDTH  = $clog2(BTB_ENTRIES),
    parameter int TARGET_WIDTH = DEF_TARGET_WIDTH,
    parameter int QUEUE_DEPTH  = DEF_QUEUE_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exValid,
    input  logic [31:0]             exPc,
    input  logic                    exTaken,
    input  logic [TARGET_WIDTH-1:0] exTarget,
    input  logic                    flushReq,
    output logic                    btbWrValid,
    input  logic                    btbWrReady,
    output logic                    btbWrInvalidate,
    output logic [INDEX_WIDTH-1:0]  btbWrIndex,
    output logic [31:0]             btbWrPc,
    output logic                    btbWrTaken,
    output logic [TARGET_WIDTH-1:0] btbWrTarget,
    output logic                    predEnable,
    output logic                    flushBusy,
    output logic [15:0]             dropCount
);

    localparam int                     CW       = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(BTB_ENTRIES - 1);

    ctrl_state_e           state;
    ctrl_state_e           state_nxt;
    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic [15:0]           drop_cnt;

    logic                  wr_done;
    logic                  in_run;
    logic                  sweep_last_done;
    logic                  upd_req;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_clear;
    logic                  q_full;
    logic                  q_empty;
    logic [CW-1:0]         q_count;
    btb_update_t           q_head;
    btb_update_t           q_head_next;
    btb_update_t           ex_upd;
    btb_update_t           load_dat;
    logic                  load_en;

    assign wr_done         = btbWrValid && btbWrReady;
    assign in_run          = (state == RUN);
    assign sweep_last_done = !in_run && wr_done && btbWrInvalidate && (sweep_idx == LAST_IDX);
    assign ex_upd          = '{pc: exPc, taken: exTaken, target: exTarget};

    // The register stage holds a copy of the queue head; the entry leaves the queue only when its write completes
    assign q_pop   = in_run && wr_done;
    assign q_clear = in_run && flushReq;
    assign upd_req = in_run && exValid && !flushReq;
    assign q_push  = upd_req && (!q_full || q_pop);

    // Choose what the write port presents next in RUN: the entry behind a completing head, a same-edge push, or the idle head
    always_comb begin
        load_dat = q_head;
        load_en  = 1'b0;
        if (btbWrValid) begin
            if (q_count >= CW'(2)) begin
                load_dat = q_head_next;
                load_en  = 1'b1;
            end else if (q_push) begin
                load_dat = ex_upd;
                load_en  = 1'b1;
            end
        end else if (!q_empty) begin
            load_dat = q_head;
            load_en  = 1'b1;
        end
    end

    btb_update_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_dat  (ex_upd),
        .pop       (q_pop),
        .clear     (q_clear),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .head_next (q_head_next),
        .count     (q_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= SWEEP;
        else      state <= state_nxt;
    end

    // FSM next state: sweep ends on the last invalidate completing, flush restarts it
    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP:   if (sweep_last_done) state_nxt = RUN;
            RUN:     if (flushReq)        state_nxt = SWEEP;
            default: state_nxt = SWEEP;
        endcase
    end

    // FSM outputs: predictions are only trusted once a full sweep has finished
    always_comb begin
        predEnable = (state == RUN);
        flushBusy  = (state == SWEEP);
    end

    // Sweep index tracks the invalidate currently presented
    always_ff @(posedge clk) begin
        if (!rst) begin
            sweep_idx <= '0;
        end else if (!in_run && wr_done && btbWrInvalidate) begin
            sweep_idx <= (sweep_idx == LAST_IDX) ? '0 : sweep_idx + INDEX_WIDTH'(1);
        end else if (q_clear) begin
            sweep_idx <= '0;
        end
    end

    // Write-port register stage; fields frozen while a write is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            btbWrValid      <= 1'b0;
            btbWrInvalidate <= 1'b0;
            btbWrIndex      <= '0;
            btbWrPc         <= '0;
            btbWrTaken      <= 1'b0;
            btbWrTarget     <= '0;
        end else if (btbWrValid && !btbWrReady) begin
            btbWrValid      <= 1'b1;
        end else if (!in_run) begin
            if (sweep_last_done) begin
                btbWrValid      <= 1'b0;
            end else begin
                // A normal write left over from a flush completes first, then the sweep starts at sweep_idx
                btbWrValid      <= 1'b1;
                btbWrInvalidate <= 1'b1;
                btbWrIndex      <= (btbWrValid && btbWrInvalidate) ? sweep_idx + INDEX_WIDTH'(1) : sweep_idx;
                btbWrPc         <= '0;
                btbWrTaken      <= 1'b0;
                btbWrTarget     <= '0;
            end
        end else if (flushReq) begin
            btbWrValid      <= 1'b0;
        end else if (load_en) begin
            btbWrValid      <= 1'b1;
            btbWrInvalidate <= 1'b0;
            btbWrIndex      <= btb_index(load_dat.pc);
            btbWrPc         <= load_dat.pc;
            btbWrTaken      <= load_dat.taken;
            btbWrTarget     <= load_dat.target;
        end else begin
            btbWrValid      <= 1'b0;
        end
    end

    // Saturating count of updates lost to a full queue; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (upd_req && q_full && !q_pop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign dropCount = drop_cnt;

endmodule
